// File: rtl/uart_rx_fifo_if.sv
// Byte stream leaving the UART receiver towards the host interface.
// A byte moves on a rising clock edge where rx_valid and rx_ready are both 1;
// rx_data is stable while rx_valid is high and rx_valid never waits on rx_ready.
interface uart_rx_fifo_if;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] rx_data;

   modport master (output rx_valid, output rx_data, input rx_ready);
   modport slave  (input rx_valid, input rx_data, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, start-glitch rejection, framing
// detection and a small byte FIFO in front of the host interface.
module uart_rx_fifo #(
   parameter int DIVISOR    = 27,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           serial_rx,
   uart_rx_fifo_if.master rx,
   output logic           framing_error,
   output logic           overrun,
   input  logic           clear_errors,
   output logic [2:0]     fsm_state
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int DIV_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
   localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIVISOR - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } state_t;

   state_t                state;
   logic                  sync1;
   logic                  rxs;
   logic [DIV_W-1:0]      div_cnt;
   logic                  tick;
   logic                  start_edge;
   logic [3:0]            sc;
   logic [2:0]            bi;
   logic [7:0]            shift;
   logic                  push_req;
   logic                  fe_set;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2:0]   wr_ptr;
   logic [DEPTH_LOG2:0]   rd_ptr;
   logic                  empty;
   logic                  full;
   logic                  pop;
   logic                  push;
   logic                  drop;

   // Both flops reset high so a reset never looks like a start edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
      end else begin
         sync1 <= serial_rx;
         rxs   <= sync1;
      end
   end

   assign start_edge = (state == IDLE) && !rxs;
   assign tick       = (div_cnt == '0);

   // Reloading on the start edge phase-aligns every sample to that edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         div_cnt <= DIV_RELOAD;
      end else if (start_edge || tick) begin
         div_cnt <= DIV_RELOAD;
      end else begin
         div_cnt <= div_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         sc       <= 4'd0;
         bi       <= 3'd0;
         shift    <= 8'd0;
         push_req <= 1'b0;
         fe_set   <= 1'b0;
      end else begin
         push_req <= 1'b0;
         fe_set   <= 1'b0;
         case (state)
            IDLE: begin
               if (!rxs) begin
                  sc    <= 4'd0;
                  state <= START;
               end
            end
            START: begin
               if (tick) begin
                  if (sc == 4'd7) begin
                     if (rxs) begin
                        state <= IDLE;
                     end else begin
                        sc    <= 4'd0;
                        bi    <= 3'd0;
                        state <= DATA;
                     end
                  end else begin
                     sc <= sc + 4'd1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  // sc wraps 15 -> 0, so each bit waits exactly 16 ticks.
                  sc <= sc + 4'd1;
                  if (sc == 4'd15) begin
                     shift <= {rxs, shift[7:1]};
                     bi    <= bi + 3'd1;
                     if (bi == 3'd7) begin
                        state <= STOP;
                     end
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  sc <= sc + 4'd1;
                  if (sc == 4'd15) begin
                     if (rxs) begin
                        push_req <= 1'b1;
                        state    <= IDLE;
                     end else begin
                        fe_set <= 1'b1;
                        state  <= BREAK;
                     end
                  end
               end
            end
            BREAK: begin
               if (rxs) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign fsm_state = state;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                  (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
   assign pop   = rx.rx_valid && rx.rx_ready;
   // A pop in the same cycle frees the slot the incoming byte needs.
   assign push  = push_req && (!full || pop);
   assign drop  = push_req && full && !pop;

   // shift is untouched until the next frame's data phase, so it is still
   // the received byte in the cycle after the stop sample.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 8'd0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= shift;
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   assign rx.rx_valid = !empty;
   assign rx.rx_data  = mem[rd_ptr[DEPTH_LOG2-1:0]];

   // A set event in the same cycle as clear_errors wins.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         framing_error <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         if (fe_set) begin
            framing_error <= 1'b1;
         end else if (clear_errors) begin
            framing_error <= 1'b0;
         end
         if (drop) begin
            overrun <= 1'b1;
         end else if (clear_errors) begin
            overrun <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized scoreboard bench for uart_rx_fifo: frames are driven on the
// serial line, expected bytes and flags come from a queue-level model.
module tb_uart_rx_fifo;

   localparam int DIVISOR    = 2;
   localparam int DEPTH_LOG2 = 2;
   localparam int DEPTH      = 4;
   localparam int BIT_CYC    = 16 * DIVISOR;
   // Line falls after edge 0; two sync flops plus the IDLE->START edge put
   // START entry at edge 3, and the stop sample 152*DIVISOR edges later.
   localparam int STOP_CYC   = 3 + 152 * DIVISOR;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       serial_rx;
   logic       framing_error;
   logic       overrun;
   logic       clear_errors;
   logic [2:0] fsm_state;

   uart_rx_fifo_if rx_if ();

   uart_rx_fifo #(.DIVISOR(DIVISOR), .DEPTH_LOG2(DEPTH_LOG2)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .serial_rx     (serial_rx),
      .rx            (rx_if),
      .framing_error (framing_error),
      .overrun       (overrun),
      .clear_errors  (clear_errors),
      .fsm_state     (fsm_state)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];
   bit         exp_fe = 1'b0;
   bit         exp_ovr = 1'b0;
   int         ready_mode = 0;
   logic [7:0] mon_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Consumer: 0 = hold off, 1 = always accept, 2 = random accept.
   initial begin
      rx_if.rx_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       rx_if.rx_ready = 1'b0;
            1:       rx_if.rx_ready = 1'b1;
            default: rx_if.rx_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: every accepted byte is compared against the scoreboard head.
   always @(negedge clk) begin
      if (reset_n && rx_if.rx_valid && rx_if.rx_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got 0x%0h, expected no byte", rx_if.rx_data);
         end else begin
            mon_exp = exp_q.pop_front();
            check("rx_byte", {24'd0, rx_if.rx_data}, {24'd0, mon_exp});
         end
      end
   end

   // Reference model: a good frame lands if there is room (or the consumer
   // frees a slot as it lands), otherwise it is lost and overrun is raised.
   task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit pop_at_stop);
      if (!stop_ok) begin
         exp_fe = 1'b1;
      end else if (exp_q.size() < DEPTH || pop_at_stop) begin
         exp_q.push_back(d);
      end else begin
         exp_ovr = 1'b1;
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int low_hold,
                             input bit pop_at_stop, input bit check_lat);
      logic [9:0] frame;
      frame = {stop_ok, d, 1'b0};
      model_frame(d, stop_ok, pop_at_stop);
      for (int c = 0; c < 10 * BIT_CYC; c++) begin
         @(posedge clk);
         if (pop_at_stop && c == STOP_CYC) ready_mode = 1;
         if (pop_at_stop && c == STOP_CYC + 1) ready_mode = 0;
         #1 serial_rx = frame[c / BIT_CYC];
         if (check_lat && (c == STOP_CYC || c == STOP_CYC + 1)) begin
            @(negedge clk);
            check((c == STOP_CYC) ? "valid_at_stop_sample" : "valid_one_after_stop",
                  {31'd0, rx_if.rx_valid}, (c == STOP_CYC + 1) ? 32'd1 : 32'd0);
         end
      end
      if (!stop_ok) begin
         repeat (low_hold) @(posedge clk);
         #1 serial_rx = 1'b1;
      end
   endtask

   task automatic send_partial(input logic [7:0] d, input int cycles);
      logic [9:0] frame;
      frame = {1'b1, d, 1'b0};
      for (int c = 0; c < cycles; c++) begin
         @(posedge clk);
         #1 serial_rx = frame[c / BIT_CYC];
      end
   endtask

   task automatic send_glitch(input int low_cycles);
      @(posedge clk);
      #1 serial_rx = 1'b0;
      repeat (low_cycles) @(posedge clk);
      #1 serial_rx = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_clear();
      @(posedge clk);
      #1 clear_errors = 1'b1;
      @(posedge clk);
      #1 clear_errors = 1'b0;
      exp_fe  = 1'b0;
      exp_ovr = 1'b0;
   endtask

   task automatic check_flags(input string name);
      @(negedge clk);
      check({name, "_framing_error"}, {31'd0, framing_error}, {31'd0, exp_fe});
      check({name, "_overrun"}, {31'd0, overrun}, {31'd0, exp_ovr});
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || rx_if.rx_valid) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drain_in_time"}, {31'd0, (n < 2000)}, 32'd1);
      check({name, "_valid_low"}, {31'd0, rx_if.rx_valid}, 32'd0);
   endtask

   initial begin
      serial_rx    = 1'b1;
      clear_errors = 1'b0;
      reset_n      = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_rx_valid", {31'd0, rx_if.rx_valid}, 32'd0);
      check("reset_rx_data", {24'd0, rx_if.rx_data}, 32'd0);
      check("reset_framing_error", {31'd0, framing_error}, 32'd0);
      check("reset_overrun", {31'd0, overrun}, 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      idle(5);

      // Basic receive with byte latency check.
      ready_mode = 1;
      send_frame(8'hA5, 1'b1, 0, 1'b0, 1'b1);
      idle(10);
      wait_drain("basic");
      check_flags("basic");

      // Start glitch shorter than half a bit, then a clean byte.
      send_glitch(10);
      idle(60);
      check("glitch_no_byte", {31'd0, rx_if.rx_valid}, 32'd0);
      send_frame(8'h3C, 1'b1, 0, 1'b0, 1'b0);
      idle(10);
      wait_drain("glitch");
      check_flags("glitch");

      // Bad stop bit with the line held low, then a good byte.
      send_frame(8'h55, 1'b0, 200 - BIT_CYC, 1'b0, 1'b0);
      idle(20);
      send_frame(8'h12, 1'b1, 0, 1'b0, 1'b0);
      idle(10);
      wait_drain("framing");
      check_flags("framing");
      pulse_clear();
      check_flags("framing_cleared");

      // Overrun: five back-to-back bytes into a four-entry FIFO.
      ready_mode = 0;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0, 1'b0, 1'b0);
      idle(5);
      check_flags("overrun");
      check("overrun_head", {24'd0, rx_if.rx_data}, {24'd0, exp_q[0]});
      ready_mode = 1;
      wait_drain("overrun");
      pulse_clear();

      // Full FIFO, push and pop in the same cycle.
      ready_mode = 0;
      for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 0, 1'b0, 1'b0);
      send_frame(8'h14, 1'b1, 0, 1'b1, 1'b0);
      idle(5);
      check_flags("full_push_pop");
      ready_mode = 1;
      wait_drain("full_push_pop");

      // Reset after data bit 3 of 0xFF, then a fresh byte.
      send_partial(8'hFF, 5 * BIT_CYC);
      #1 reset_n = 1'b0;
      exp_q.delete();
      exp_fe  = 1'b0;
      exp_ovr = 1'b0;
      serial_rx = 1'b1;
      idle(4);
      check("midreset_valid", {31'd0, rx_if.rx_valid}, 32'd0);
      reset_n = 1'b1;
      idle(BIT_CYC * 6);
      check("midreset_empty_after", {31'd0, rx_if.rx_valid}, 32'd0);
      send_frame(8'h81, 1'b1, 0, 1'b0, 1'b0);
      idle(10);
      wait_drain("midreset");
      check_flags("midreset");

      // Random bytes, random gaps, random consumer, occasional bad stop bit.
      ready_mode = 2;
      for (int i = 0; i < 12; i++) begin
         send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 4) != 0),
                    $urandom_range(20, 80), 1'b0, 1'b0);
         idle($urandom_range(0, 20));
      end
      ready_mode = 1;
      wait_drain("random");
      check_flags("random");

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout: simulation did not complete, got timeout, expected completion");
      $fatal(1, "timeout");
   end

endmodule
